icache_2way: RTL and testbench
==============================

Name: icache_2way

Overview:
- Parametrised 2-way set-associative instruction cache; next generation of the direct-mapped fetch-stage cache.
- Sits between the fetch stage and the memory arbiter. Returns one instruction word per hit in the same cycle.
- Runs a registered refill state machine with a latched miss address, per-set LRU replacement, a whole-cache flush and a saturating miss counter.

Parameters:
- LINE_WIDTH, 256: bits per cache line, equal to the memory refill width.
- WORD_WIDTH, 16: instruction word width. LINE_WIDTH/WORD_WIDTH must be a power of two.
- ADDR_WIDTH, 16: word-address width.
- NUM_SETS, 4: number of sets, power of two, at least 2.
- CNT_WIDTH, 16: miss counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  fetch word address. Split is {tag, index, offset}: OFF_BITS=log2(LINE_WIDTH/WORD_WIDTH), IDX_BITS=log2(NUM_SETS), TAG_BITS=ADDR_WIDTH-IDX_BITS-OFF_BITS.
- petFromProc  in  1  fetch request valid.
- flush  in  1  invalidate all lines.
- memServiceReady  in  1  arbiter: dataReadFromMem is valid this cycle.
- dataReadFromMem  in  LINE_WIDTH  refill line; word k is bits [k*WORD_WIDTH +: WORD_WIDTH].
- instructionBits  out  WORD_WIDTH  selected word from the hitting way; 0 when isHit=0.
- isHit  out  1  lookup hit, qualified by state==IDLE.
- addrToArb  out  ADDR_WIDTH  line-aligned refill address (offset bits zero).
- petitionToArb  out  1  refill request to the arbiter.
- missCount  out  CNT_WIDTH  saturating count of misses.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all valid bits=0; all LRU bits=0; missCount=0.
  - Outputs: isHit=0, petitionToArb=0, instructionBits=0.
  - Tag and data arrays are not reset.
  - Reset overrides every other input, including in the middle of a refill.
- Lookup (combinational):
  - hit_w = valid[w][idx] && tag[w][idx]==address tag.
  - isHit = petFromProc && (hit_0||hit_1) && state==IDLE.
  - Both ways hitting is illegal; assert on it.
- IDLE:
  - On a hit, set LRU[idx] to the other way (the way not used). addrToArb = current address, line-aligned.
  - On a miss (petFromProc && !hit && !flush): latch address into missAddr, increment missCount (hold at all-ones), go to REQ.
- REQ:
  - petitionToArb=1; addrToArb = missAddr line-aligned; isHit=0.
  - The address and petFromProc inputs are ignored; the refill always completes once started.
  - On memServiceReady, write the victim way of set missAddr.idx:
    - victim is way0 if it is invalid, else way1 if it is invalid, else LRU[idx];
    - set data, tag and valid; point LRU at the other way;
    - return to IDLE.
  - Latency: the line is hittable the cycle after memServiceReady. Miss to hit takes at least 2 cycles.
- Flush:
  - Clears every valid bit at the edge and does not touch LRU.
  - In IDLE it suppresses miss detection for that cycle.
  - In REQ the refill still completes. A line written in the same cycle as flush ends up valid, because the write beats the flush for that entry.
- memServiceReady in IDLE is ignored.

Decomposition:
- Package icache_pkg holds:
  - functions for OFF_BITS, IDX_BITS and TAG_BITS;
  - state encoding IDLE=1'b0, REQ=1'b1;
  - the way-select constants.
- Sub-module icache_way, instantiated twice, provides storage for one way:
  - NUM_SETS × (valid, tag, line), with a write port, flush-clear and an asynchronous read by index;
  - outputs hit and the selected word.
- Top level keeps the FSM, LRU, victim selection, missAddr and missCount.

Test Plan:
- Reset, petFromProc=1, address=0x0043 -> isHit=0, petitionToArb=1, addrToArb=0x0040, missCount=1. Drive memServiceReady=1 with word3=0xBEEF -> next cycle isHit=1, instructionBits=0xBEEF, petitionToArb=0.
- Fill 0x0000 (word0=0x1111), then 0x0040 (word0=0x2222), both in set 0 -> both hit afterwards with 0x1111 and 0x2222; missCount=2.
- Then hit 0x0000, miss 0x0080 -> the way holding 0x0040 is replaced; 0x0000 still hits, 0x0040 misses; missCount=4.
- Enter REQ for 0x0040, change address to 0x0100 before memServiceReady -> isHit=0 throughout, addrToArb stays 0x0040, the refill lands at set 0, then 0x0040 hits.
- flush=1 for one cycle with set 0 holding two lines -> next cycle 0x0000 and 0x0040 both miss. flush coincident with memServiceReady -> the refilled line hits.
- reset asserted while in REQ -> next cycle petitionToArb=0, missCount=0, every address misses. Force missCount to all-ones and take a further miss -> missCount holds at 0xFFFF.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the 2-way set-associative instruction cache:
//   - address-field width helpers (offset / index / tag),
//   - refill state encoding,
//   - way-select constants used by victim selection and LRU.
// -----------------------------------------------------------------------------
package icache_pkg;

    // Word-offset bits inside one line.
    function automatic int offBits(input int lineWidth, input int wordWidth);
        return $clog2(lineWidth / wordWidth);
    endfunction

    // Set-index bits.
    function automatic int idxBits(input int numSets);
        return $clog2(numSets);
    endfunction

    // Remaining upper address bits form the tag.
    function automatic int tagBits(input int addrWidth, input int lineWidth,
                                   input int wordWidth, input int numSets);
        return addrWidth - idxBits(numSets) - offBits(lineWidth, wordWidth);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } cacheState_e;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

endpackage

// File: rtl/icache_way.sv
// -----------------------------------------------------------------------------
// icache_way
// Storage for one way: NUM_SETS entries of (valid, tag, line).
// Ports:
//   clk, reset       clock, synchronous active-high reset (valid bits only)
//   flush            clear every valid bit at the edge
//   writeEn          write writeTag/writeLine into set writeIdx and mark valid
//   writeIdx/Tag/Line refill write port
//   writeSlotValid   current valid bit of set writeIdx (victim selection)
//   readIdx/Tag/Off  asynchronous lookup port
//   hit              valid && tag match at readIdx
//   word             word readOff of the line at readIdx (unqualified)
// -----------------------------------------------------------------------------
module icache_way
    import icache_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SETS   = 4,
    localparam int OFF_BITS  = offBits(LINE_WIDTH, WORD_WIDTH),
    localparam int IDX_BITS  = idxBits(NUM_SETS),
    localparam int TAG_BITS  = tagBits(ADDR_WIDTH, LINE_WIDTH, WORD_WIDTH, NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  writeEn,
    input  logic [IDX_BITS-1:0]   writeIdx,
    input  logic [TAG_BITS-1:0]   writeTag,
    input  logic [LINE_WIDTH-1:0] writeLine,
    output logic                  writeSlotValid,
    input  logic [IDX_BITS-1:0]   readIdx,
    input  logic [TAG_BITS-1:0]   readTag,
    input  logic [OFF_BITS-1:0]   readOff,
    output logic                  hit,
    output logic [WORD_WIDTH-1:0] word
);

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_BITS-1:0]   tags  [NUM_SETS];
    logic [LINE_WIDTH-1:0] lines [NUM_SETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (flush) begin
                valid <= '0;
            end
            // NOTE: non-blocking assignments to the same bit resolve to the
            // last one, so a refill written in the flush cycle stays valid.
            if (writeEn) begin
                valid[writeIdx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays have no reset; the valid bits alone decide
    // whether an entry means anything, and this keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            tags[writeIdx]  <= writeTag;
            lines[writeIdx] <= writeLine;
        end
    end

    assign writeSlotValid = valid[writeIdx];
    assign hit            = valid[readIdx] && (tags[readIdx] == readTag);
    assign word           = lines[readIdx][int'(readOff) * WORD_WIDTH +: WORD_WIDTH];

endmodule

// File: rtl/icache_2way.sv
// -----------------------------------------------------------------------------
// icache_2way
// 2-way set-associative instruction cache with same-cycle hit data, a
// registered refill FSM, per-set LRU, whole-cache flush and a saturating
// miss counter.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   address           fetch word address {tag, index, offset}
//   petFromProc       fetch request valid
//   flush             invalidate all lines
//   memServiceReady   dataReadFromMem holds the refill line this cycle
//   dataReadFromMem   refill line, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   instructionBits   hitting word, 0 when no hit
//   isHit             lookup hit (only in IDLE)
//   addrToArb         line-aligned refill address
//   petitionToArb     refill request to the arbiter
//   missCount         saturating miss counter
// -----------------------------------------------------------------------------
module icache_2way
    import icache_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SETS   = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int OFF_BITS  = offBits(LINE_WIDTH, WORD_WIDTH),
    localparam int IDX_BITS  = idxBits(NUM_SETS),
    localparam int TAG_BITS  = tagBits(ADDR_WIDTH, LINE_WIDTH, WORD_WIDTH, NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  petFromProc,
    input  logic                  flush,
    input  logic                  memServiceReady,
    input  logic [LINE_WIDTH-1:0] dataReadFromMem,
    output logic [WORD_WIDTH-1:0] instructionBits,
    output logic                  isHit,
    output logic [ADDR_WIDTH-1:0] addrToArb,
    output logic                  petitionToArb,
    output logic [CNT_WIDTH-1:0]  missCount
);

    cacheState_e           state, stateNext;
    logic [NUM_SETS-1:0]   lru;        // per set: the way to replace next
    logic [ADDR_WIDTH-1:0] missAddr;

    logic [TAG_BITS-1:0]   reqTag, missTag;
    logic [IDX_BITS-1:0]   reqIdx, missIdx;
    logic [OFF_BITS-1:0]   reqOff;

    logic                  hit0, hit1, anyHit;
    logic                  slotValid0, slotValid1;
    logic [WORD_WIDTH-1:0] word0, word1;
    logic                  refillDone, startMiss, victim;

    assign reqTag  = address[ADDR_WIDTH-1 -: TAG_BITS];
    assign reqIdx  = address[OFF_BITS +: IDX_BITS];
    assign reqOff  = address[OFF_BITS-1:0];
    assign missTag = missAddr[ADDR_WIDTH-1 -: TAG_BITS];
    assign missIdx = missAddr[OFF_BITS +: IDX_BITS];
    assign anyHit  = hit0 || hit1;

    icache_way #(
        .LINE_WIDTH(LINE_WIDTH), .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_SETS(NUM_SETS)
    ) way0 (
        .clk(clk), .reset(reset), .flush(flush),
        .writeEn(refillDone && (victim == WAY0)),
        .writeIdx(missIdx), .writeTag(missTag), .writeLine(dataReadFromMem),
        .writeSlotValid(slotValid0),
        .readIdx(reqIdx), .readTag(reqTag), .readOff(reqOff),
        .hit(hit0), .word(word0)
    );

    icache_way #(
        .LINE_WIDTH(LINE_WIDTH), .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_SETS(NUM_SETS)
    ) way1 (
        .clk(clk), .reset(reset), .flush(flush),
        .writeEn(refillDone && (victim == WAY1)),
        .writeIdx(missIdx), .writeTag(missTag), .writeLine(dataReadFromMem),
        .writeSlotValid(slotValid1),
        .readIdx(reqIdx), .readTag(reqTag), .readOff(reqOff),
        .hit(hit1), .word(word1)
    );

    // Invalid ways are filled first; with both valid the LRU pick applies.
    always_comb begin
        if (!slotValid0) begin
            victim = WAY0;
        end else if (!slotValid1) begin
            victim = WAY1;
        end else begin
            victim = lru[missIdx];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        stateNext       = state;
        isHit           = 1'b0;
        instructionBits = '0;
        petitionToArb   = 1'b0;
        addrToArb       = {address[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
        refillDone      = 1'b0;
        startMiss       = 1'b0;
        case (state)
            IDLE: begin
                isHit = petFromProc && anyHit;
                if (isHit) begin
                    instructionBits = hit0 ? word0 : word1;
                end
                // Flush suppresses miss detection: the line would be
                // invalidated by the same edge anyway.
                if (petFromProc && !anyHit && !flush) begin
                    startMiss = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                petitionToArb = 1'b1;
                addrToArb     = {missAddr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                if (memServiceReady) begin
                    refillDone = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lru       <= '0;
            missCount <= '0;
        end else begin
            state <= stateNext;
            if (isHit) begin
                lru[reqIdx] <= hit0 ? WAY1 : WAY0;
            end
            if (startMiss) begin
                missAddr <= address;
                if (missCount != {CNT_WIDTH{1'b1}}) begin
                    missCount <= missCount + CNT_WIDTH'(1);
                end
            end
            if (refillDone) begin
                lru[missIdx] <= ~victim;
            end
        end
    end

    // A line is only ever refilled after missing in both ways, so two
    // simultaneous hits mean corrupted tag state.
    assert property (@(posedge clk) disable iff (reset) !(hit0 && hit1));

endmodule

// File: tb/tb_icache_2way.sv
// -----------------------------------------------------------------------------
// tb_icache_2way
// Directed stimulus for icache_2way. A behavioural cache model (sets of two
// entries, replace-first-invalid-else-LRU) predicts every output each cycle;
// hand-computed literal expectations pin the model. A second instance with a
// 2-bit counter exercises miss-counter saturation.
// -----------------------------------------------------------------------------
module tb_icache_2way;

    localparam int LW = 256;
    localparam int WW = 16;
    localparam int AW = 16;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          petFromProc = 1'b0;
    logic          flush = 1'b0;
    logic          memServiceReady = 1'b0;
    logic [LW-1:0] dataReadFromMem = '0;

    logic [WW-1:0] instructionBits;
    logic          isHit;
    logic [AW-1:0] addrToArb;
    logic          petitionToArb;
    logic [15:0]   missCount;

    logic [WW-1:0] satInstr;
    logic          satHit;
    logic [AW-1:0] satArb;
    logic          satPet;
    logic [1:0]    satCount;

    int cmpCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    icache_2way #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW),
                  .NUM_SETS(NS), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .address(address), .petFromProc(petFromProc),
        .flush(flush), .memServiceReady(memServiceReady),
        .dataReadFromMem(dataReadFromMem), .instructionBits(instructionBits),
        .isHit(isHit), .addrToArb(addrToArb), .petitionToArb(petitionToArb),
        .missCount(missCount)
    );

    icache_2way #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW),
                  .NUM_SETS(NS), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .reset(reset), .address(address), .petFromProc(petFromProc),
        .flush(flush), .memServiceReady(memServiceReady),
        .dataReadFromMem(dataReadFromMem), .instructionBits(satInstr),
        .isHit(satHit), .addrToArb(satArb), .petitionToArb(satPet),
        .missCount(satCount)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Line whose word k holds base+k.
    function automatic logic [LW-1:0] mkLine(input logic [15:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / WW; k++) begin
            l[k*WW +: WW] = base + 16'(k);
        end
        return l;
    endfunction

    // ---------------- behavioural model ----------------
    bit            mValid [2][NS];
    bit [9:0]      mTag   [2][NS];
    logic [LW-1:0] mLine  [2][NS];
    int            mLru   [NS];     // way to evict next when the set is full
    bit            mRefill;
    logic [AW-1:0] mMissAddr;
    int            mCount;
    bit            modelLive = 1'b0;

    function automatic int findWay(input logic [AW-1:0] a);
        int found = -1;
        for (int w = 0; w < 2; w++) begin
            if (mValid[w][a[5:4]] && mTag[w][a[5:4]] == a[15:6]) found = w;
        end
        return found;
    endfunction

    function automatic void clearValid();
        for (int w = 0; w < 2; w++) for (int s = 0; s < NS; s++) mValid[w][s] = 1'b0;
    endfunction

    int mHw, mV, mSet;
    always @(posedge clk) begin
        if (reset) begin
            clearValid();
            for (int s = 0; s < NS; s++) mLru[s] = 0;
            mRefill   = 1'b0;
            mCount    = 0;
            modelLive = 1'b1;
        end else if (!mRefill) begin
            mHw = findWay(address);
            if (petFromProc && mHw >= 0) begin
                mLru[address[5:4]] = 1 - mHw;
            end else if (petFromProc && !flush) begin
                mMissAddr = address;
                mRefill   = 1'b1;
                if (mCount < 65535) mCount++;
            end
            if (flush) clearValid();
        end else begin
            mSet = mMissAddr[5:4];
            if (!mValid[0][mSet])      mV = 0;
            else if (!mValid[1][mSet]) mV = 1;
            else                       mV = mLru[mSet];
            if (flush) clearValid();
            if (memServiceReady) begin
                mValid[mV][mSet] = 1'b1;
                mTag[mV][mSet]   = mMissAddr[15:6];
                mLine[mV][mSet]  = dataReadFromMem;
                mLru[mSet]       = 1 - mV;
                mRefill          = 1'b0;
            end
        end
    end

    int eW;
    logic          eHit;
    logic [WW-1:0] eWord;
    logic [AW-1:0] eArb;
    always @(negedge clk) begin
        if (modelLive) begin
            eW    = findWay(address);
            eHit  = !mRefill && petFromProc && (eW >= 0);
            eWord = '0;
            if (eHit) eWord = mLine[eW][address[5:4]][int'(address[3:0]) * WW +: WW];
            eArb  = mRefill ? {mMissAddr[15:4], 4'h0} : {address[15:4], 4'h0};
            check("model isHit", 32'(isHit), 32'(eHit));
            check("model instructionBits", 32'(instructionBits), 32'(eWord));
            check("model petitionToArb", 32'(petitionToArb), 32'(mRefill));
            check("model addrToArb", 32'(addrToArb), 32'(eArb));
            check("model missCount", 32'(missCount), 32'(mCount));
            check("model satCount", 32'(satCount), 32'((mCount > 3) ? 3 : mCount));
        end
    end

    // One cycle: apply inputs after the edge, return at the following negedge.
    task automatic drive(input bit rst, input bit pet, input logic [AW-1:0] a,
                         input bit fl, input bit rdy, input logic [15:0] base);
        @(posedge clk);
        #1;
        reset           = rst;
        petFromProc     = pet;
        address         = a;
        flush           = fl;
        memServiceReady = rdy;
        dataReadFromMem = mkLine(base);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        drive(1, 0, 16'h0000, 0, 0, 16'h0);
        drive(1, 0, 16'h0000, 0, 0, 16'h0);
        check("reset isHit", 32'(isHit), 0);
        check("reset petitionToArb", 32'(petitionToArb), 0);
        check("reset instructionBits", 32'(instructionBits), 0);
        check("reset missCount", 32'(missCount), 0);

        // First miss and refill of 0x0043
        drive(0, 1, 16'h0043, 0, 0, 16'h0);
        check("t1 miss isHit", 32'(isHit), 0);
        drive(0, 1, 16'h0043, 0, 1, 16'hBEEC);
        check("t1 req petition", 32'(petitionToArb), 1);
        check("t1 req addrToArb", 32'(addrToArb), 32'h0040);
        check("t1 req missCount", 32'(missCount), 1);
        drive(0, 1, 16'h0043, 0, 0, 16'h0);
        check("t1 refilled isHit", 32'(isHit), 1);
        check("t1 refilled word", 32'(instructionBits), 32'hBEEF);
        check("t1 refilled petition", 32'(petitionToArb), 0);

        // Two lines in set 0
        drive(1, 0, 16'h0000, 0, 0, 16'h0);
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        drive(0, 1, 16'h0000, 0, 1, 16'h1111);
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        drive(0, 1, 16'h0040, 0, 1, 16'h2222);
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        check("t2 hit 0x0000", 32'(instructionBits), 32'h1111);
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        check("t2 hit 0x0040", 32'(instructionBits), 32'h2222);
        check("t2 missCount", 32'(missCount), 2);

        // LRU replacement: touch 0x0000, then 0x0080 evicts 0x0040
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        drive(0, 1, 16'h0080, 0, 0, 16'h0);
        drive(0, 1, 16'h0080, 0, 1, 16'h3333);
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        check("t3 0x0000 still hits", 32'(instructionBits), 32'h1111);
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        check("t3 0x0040 evicted", 32'(isHit), 0);

        // Address changes while refilling 0x0040
        drive(0, 1, 16'h0100, 0, 0, 16'h0);
        check("t3 missCount", 32'(missCount), 4);
        check("t4 req isHit", 32'(isHit), 0);
        check("t4 req addrToArb", 32'(addrToArb), 32'h0040);
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        check("t4 req ignores resident line", 32'(isHit), 0);
        check("t4 req addrToArb held", 32'(addrToArb), 32'h0040);
        drive(0, 1, 16'h0100, 0, 1, 16'h4444);
        check("t4 ready cycle isHit", 32'(isHit), 0);
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        check("t4 0x0040 hits", 32'(instructionBits), 32'h4444);

        // Flush
        drive(0, 1, 16'h0000, 1, 0, 16'h0);
        check("t5 hit during flush cycle", 32'(isHit), 1);
        drive(0, 1, 16'h0040, 1, 0, 16'h0);
        check("t5 0x0040 flushed", 32'(isHit), 0);
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        check("t5 flush suppressed miss", 32'(petitionToArb), 0);
        check("t5 0x0000 flushed", 32'(isHit), 0);
        drive(0, 1, 16'h0000, 1, 1, 16'h5555);
        check("t5 refill req", 32'(petitionToArb), 1);
        drive(0, 1, 16'h0000, 0, 0, 16'h0);
        check("t5 write beats flush", 32'(instructionBits), 32'h5555);
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        check("t5 0x0040 still gone", 32'(isHit), 0);

        // Reset in the middle of a refill
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        check("t6 in req", 32'(petitionToArb), 1);
        drive(1, 1, 16'h0040, 0, 1, 16'h6666);
        drive(0, 0, 16'h0040, 0, 0, 16'h0);
        check("t6 reset petition", 32'(petitionToArb), 0);
        check("t6 reset missCount", 32'(missCount), 0);
        drive(0, 1, 16'h0000, 1, 0, 16'h0);
        check("t6 0x0000 misses", 32'(isHit), 0);
        drive(0, 1, 16'h0040, 0, 0, 16'h0);
        check("t6 0x0040 misses", 32'(isHit), 0);

        // Counter saturation on the 2-bit instance
        drive(0, 0, 16'h0000, 0, 1, 16'h7777);
        for (int k = 2; k <= 4; k++) begin
            drive(0, 1, 16'(k * 16'h0040), 0, 0, 16'h0);
            drive(0, 0, 16'h0000, 0, 1, 16'(k * 16'h1000));
        end
        drive(0, 0, 16'h0000, 0, 0, 16'h0);
        check("t7 missCount", 32'(missCount), 4);
        check("t7 saturated count", 32'(satCount), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
